// File: rtl/iic_pkg.sv
// Shared I2C definitions: FSM state encoding and bus-level bit meanings.
// Used by both the target register file and the initiator.
package iic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_WDATA,
    ST_RDATA,
    ST_IGNORE
  } iic_state_e;

  localparam logic IIC_ACK      = 1'b0;
  localparam logic IIC_NACK     = 1'b1;
  localparam logic IIC_RW_WRITE = 1'b0;
  localparam logic IIC_RW_READ  = 1'b1;

endpackage

// File: rtl/iic_target_regfile_if.sv
// Host-side port of the I2C target: register update input, commit/read
// strobes, busy flag and the FSM state for observation.
interface iic_target_regfile_if;
  import iic_pkg::*;

  // Every strobe here (upd_en, wr_valid, rd_strobe) is a single-cycle pulse
  // with its address/data valid in the same cycle; there is no ready, so the
  // receiver must accept on the pulse.
  logic       upd_en;
  logic [7:0] upd_addr;
  logic [7:0] upd_data;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_strobe;
  logic [7:0] rd_addr;
  logic       busy;
  iic_state_e state;

  modport master (
    output upd_en, upd_addr, upd_data,
    input  wr_valid, wr_addr, wr_data, rd_strobe, rd_addr, busy, state
  );

  modport slave (
    input  upd_en, upd_addr, upd_data,
    output wr_valid, wr_addr, wr_data, rd_strobe, rd_addr, busy, state
  );

endinterface

// File: rtl/iic_line_filter.sv
// Two-flop synchronizer plus a run-length glitch filter for one I2C line,
// with single-cycle rise/fall pulses aligned to the filtered level change.
module iic_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q, fall_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // A new level is accepted only after FILTER_LEN consecutive differing samples.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) level_d = sync2_q;
      else                              cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= level_d & ~level_q;
      fall_q  <= ~level_d & level_q;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/iic_target_regfile.sv
// I2C target with a byte register file: address, register pointer, burst
// write or repeated-start burst read with pointer auto-increment.
module iic_target_regfile
  import iic_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = 7'h68,
  parameter int         REG_DEPTH  = 128,
  parameter int         FILTER_LEN = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scl,
  inout  wire                  sda,
  iic_target_regfile_if.slave  bus
);

  localparam int AW = $clog2(REG_DEPTH);

  function automatic logic in_range(input logic [7:0] a);
    return {1'b0, a} < 9'(REG_DEPTH);
  endfunction

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  iic_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(clk), .rst(rst), .din(scl), .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  iic_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(clk), .rst(rst), .din(sda), .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  iic_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] ptr_q, ptr_d;
  logic       rw_q, rw_d;
  logic       sda_low_q, sda_low_d;
  logic       busy_q, busy_d;
  logic       wr_valid_q, wr_valid_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       rd_strobe_q, rd_strobe_d;
  logic [7:0] rd_addr_q, rd_addr_d;
  logic       commit_en;
  logic       upd_hit;
  logic [7:0] rd_byte;
  logic [7:0] shift_in;
  logic       start_det, stop_det;
  logic [7:0] regs_q [REG_DEPTH];

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign shift_in  = {sh_q[6:0], sda_lvl};
  assign rd_byte   = in_range(ptr_q) ? regs_q[ptr_q[AW-1:0]] : 8'h00;
  assign upd_hit   = bus.upd_en & in_range(bus.upd_addr);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sh_d        = sh_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    sda_low_d   = sda_low_q;
    busy_d      = busy_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_strobe_d = 1'b0;
    rd_addr_d   = rd_addr_q;
    commit_en   = 1'b0;
    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 4'd0;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 4'd0;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR: if (scl_rise) begin
          sh_d      = shift_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            rw_d = sda_lvl;
            if (sh_q[6:0] == DEV_ADDR) begin
              busy_d  = 1'b1;
              state_d = ST_ADDR_ACK;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        // First fall drives the ACK; the second ends the ACK slot.
        ST_ADDR_ACK: if (scl_fall) begin
          if (!sda_low_q) begin
            sda_low_d = 1'b1;
          end else if (rw_q == IIC_RW_WRITE) begin
            sda_low_d = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = ST_REG;
          end else begin
            sh_d        = rd_byte;
            sda_low_d   = ~rd_byte[7];
            rd_strobe_d = 1'b1;
            rd_addr_d   = ptr_q;
            bit_cnt_d   = 4'd0;
            state_d     = ST_RDATA;
          end
        end
        ST_REG, ST_WDATA: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            sh_d      = shift_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (state_q == ST_REG && bit_cnt_q == 4'd7) ptr_d = shift_in;
          end else if (scl_rise && state_q == ST_WDATA) begin
            commit_en  = in_range(ptr_q);
            wr_valid_d = 1'b1;
            wr_addr_d  = ptr_q;
            wr_data_d  = sh_q;
            ptr_d      = ptr_q + 8'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (!sda_low_q) begin
              sda_low_d = 1'b1;
            end else begin
              sda_low_d = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = ST_WDATA;
            end
          end
        end
        // bit_cnt: 0..7 data bits on the line, 8 = initiator ACK slot, 9 = ACK seen.
        ST_RDATA: begin
          if (scl_fall && bit_cnt_q < 4'd7) begin
            sh_d      = {sh_q[6:0], 1'b0};
            sda_low_d = ~sh_q[6];
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd7) begin
            sda_low_d = 1'b0;
            bit_cnt_d = 4'd8;
          end else if (scl_rise && bit_cnt_q == 4'd8) begin
            if (sda_lvl == IIC_ACK) begin
              ptr_d     = ptr_q + 8'd1;
              bit_cnt_d = 4'd9;
            end else begin
              busy_d  = 1'b0;
              state_d = ST_IGNORE;
            end
          end else if (scl_fall && bit_cnt_q == 4'd9) begin
            sh_d        = rd_byte;
            sda_low_d   = ~rd_byte[7];
            rd_strobe_d = 1'b1;
            rd_addr_d   = ptr_q;
            bit_cnt_d   = 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 4'd0;
      sh_q        <= 8'h00;
      ptr_q       <= 8'h00;
      rw_q        <= 1'b0;
      sda_low_q   <= 1'b0;
      busy_q      <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= 8'h00;
      wr_data_q   <= 8'h00;
      rd_strobe_q <= 1'b0;
      rd_addr_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sh_q        <= sh_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      sda_low_q   <= sda_low_d;
      busy_q      <= busy_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_strobe_q <= rd_strobe_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

  // The bus commit is written last so it wins over a same-index host update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_DEPTH; i++) regs_q[i] <= 8'h00;
    end else begin
      if (upd_hit)   regs_q[bus.upd_addr[AW-1:0]] <= bus.upd_data;
      if (commit_en) regs_q[ptr_q[AW-1:0]]        <= sh_q;
    end
  end

  assign sda           = sda_low_q ? 1'b0 : 1'bz;
  assign bus.wr_valid  = wr_valid_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.rd_strobe = rd_strobe_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.busy      = busy_q;
  assign bus.state     = state_q;

endmodule
